// File: rtl/sgmii_link_manager.sv
// rtl/sgmii_link_manager.sv - SGMII PCS bring-up and link supervision as a Wishbone master
// Programs advertisement, restarts AN, reads partner ability, retries on timeout, restarts on link loss.
module sgmii_link_manager #(
  parameter logic [7:0]  P_ADDR_CTRL    = 8'h00,
  parameter logic [7:0]  P_ADDR_ADV     = 8'h04,
  parameter logic [7:0]  P_ADDR_LPA     = 8'h05,
  parameter logic [15:0] P_ADV          = 16'h4001,
  parameter logic [15:0] P_CTRL_RESTART = 16'h1200,
  parameter logic [15:0] P_CTRL_RUN     = 16'h1000,
  parameter logic [23:0] P_LINK_TO      = 24'd1_250_000,
  parameter logic [23:0] P_AN_TO        = 24'd1_250_000,
  parameter logic [7:0]  P_BUS_TO       = 8'd64,
  parameter logic [1:0]  P_MAX_RETRY    = 2'd3
) (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  input  logic        i_Enable,
  output logic        o_Cyc,
  output logic        o_Stb,
  output logic        o_WEn,
  output logic [7:0]  o8_Addr,
  output logic [31:0] o32_WrData,
  input  logic [31:0] i32_RdData,
  input  logic        i_Ack,
  input  logic        i_Linkup,
  input  logic        i_ANDone,
  output logic        o_Up,
  output logic        o_Fail,
  output logic [3:0]  o4_State,
  output logic [1:0]  o2_Retries,
  output logic [7:0]  o8_LinkDrops,
  output logic [15:0] o16_LpAbility
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ADV    = 4'd1,
    WR_RST    = 4'd2,
    WR_RUN    = 4'd3,
    WAIT_LINK = 4'd4,
    WAIT_AN   = 4'd5,
    RD_LPA    = 4'd6,
    UP        = 4'd7,
    FAIL      = 4'd8
  } tState;

  tState       state, stateNxt;
  logic [23:0] timer, timerNxt;
  logic        cyc, cycNxt;
  logic        wen, wenNxt;
  logic [7:0]  addr, addrNxt;
  logic [15:0] wrData, wrDataNxt;
  logic [1:0]  retries, retriesNxt;
  logic [7:0]  drops, dropsNxt;
  logic [15:0] lpAbility, lpAbilityNxt;
  logic        up, upNxt;
  logic        fail, failNxt;
  logic        busDone, busTimeout, retryAvail, inWait;
  logic        unusedRdHi;

  assign unusedRdHi = ^i32_RdData[31:16];

  function automatic logic isBusState(input tState s);
    return (s == WR_ADV) || (s == WR_RST) || (s == WR_RUN) || (s == RD_LPA);
  endfunction

  assign busDone    = cyc & i_Ack;
  assign busTimeout = cyc & ~i_Ack & (timer == {16'd0, P_BUS_TO});
  assign retryAvail = retries < P_MAX_RETRY;
  assign inWait     = (state == WAIT_LINK) || (state == WAIT_AN);

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state     <= IDLE;
      timer     <= '0;
      cyc       <= 1'b0;
      wen       <= 1'b0;
      addr      <= '0;
      wrData    <= '0;
      retries   <= '0;
      drops     <= '0;
      lpAbility <= '0;
      up        <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= stateNxt;
      timer     <= timerNxt;
      cyc       <= cycNxt;
      wen       <= wenNxt;
      addr      <= addrNxt;
      wrData    <= wrDataNxt;
      retries   <= retriesNxt;
      drops     <= dropsNxt;
      lpAbility <= lpAbilityNxt;
      up        <= upNxt;
      fail      <= failNxt;
    end
  end

  // An open bus cycle always runs to ack or timeout before enable is honoured.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (i_Enable) stateNxt = WR_ADV;
      WR_ADV, WR_RST, WR_RUN, RD_LPA: begin
        if (busDone) begin
          if (!i_Enable)             stateNxt = IDLE;
          else if (state == WR_ADV)  stateNxt = WR_RST;
          else if (state == WR_RST)  stateNxt = WR_RUN;
          else if (state == WR_RUN)  stateNxt = WAIT_LINK;
          else                       stateNxt = UP;
        end else if (busTimeout) begin
          stateNxt = i_Enable ? FAIL : IDLE;
        end else if (!cyc && !i_Enable) begin
          stateNxt = IDLE;
        end
      end
      WAIT_LINK: begin
        if (!i_Enable)               stateNxt = IDLE;
        else if (i_Linkup)           stateNxt = WAIT_AN;
        else if (timer == P_LINK_TO) stateNxt = retryAvail ? WR_RST : FAIL;
      end
      WAIT_AN: begin
        if (!i_Enable)             stateNxt = IDLE;
        else if (!i_Linkup)        stateNxt = WAIT_LINK;
        else if (i_ANDone)         stateNxt = RD_LPA;
        else if (timer == P_AN_TO) stateNxt = retryAvail ? WR_RST : FAIL;
      end
      UP: begin
        if (!i_Enable)      stateNxt = IDLE;
        else if (!i_Linkup) stateNxt = WR_RST;
      end
      FAIL:    if (!i_Enable) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    cycNxt       = cyc;
    wenNxt       = wen;
    addrNxt      = addr;
    wrDataNxt    = wrData;
    timerNxt     = timer;
    retriesNxt   = retries;
    dropsNxt     = drops;
    lpAbilityNxt = lpAbility;
    if (cyc) begin
      if (i_Ack || busTimeout) begin
        cycNxt    = 1'b0;
        wenNxt    = 1'b0;
        addrNxt   = '0;
        wrDataNxt = '0;
        timerNxt  = '0;
      end else begin
        timerNxt = timer + 24'd1;
      end
    end else if (isBusState(stateNxt) && (stateNxt == state || state == IDLE)) begin
      // Leaving IDLE opens the first cycle at once; later states open one edge after entry.
      cycNxt   = 1'b1;
      timerNxt = '0;
      case (stateNxt)
        WR_ADV:  begin wenNxt = 1'b1; addrNxt = P_ADDR_ADV;  wrDataNxt = P_ADV;          end
        WR_RST:  begin wenNxt = 1'b1; addrNxt = P_ADDR_CTRL; wrDataNxt = P_CTRL_RESTART; end
        WR_RUN:  begin wenNxt = 1'b1; addrNxt = P_ADDR_CTRL; wrDataNxt = P_CTRL_RUN;     end
        default: begin wenNxt = 1'b0; addrNxt = P_ADDR_LPA;  wrDataNxt = '0;             end
      endcase
    end else if (inWait) begin
      timerNxt = (stateNxt == state) ? timer + 24'd1 : '0;
    end

    if (stateNxt == IDLE) begin
      retriesNxt = '0;
    end else if (inWait && stateNxt == WR_RST) begin
      retriesNxt = retries + 2'd1;
    end else if (state == UP && stateNxt == WR_RST) begin
      retriesNxt = '0;
      if (drops != 8'hFF) dropsNxt = drops + 8'd1;
    end
    if (state == RD_LPA && busDone) begin
      lpAbilityNxt = i32_RdData[15:0];
      retriesNxt   = '0;
    end
    upNxt   = (stateNxt == UP);
    failNxt = (stateNxt == FAIL);
  end

  assign o_Cyc         = cyc;
  assign o_Stb         = cyc;
  assign o_WEn         = wen;
  assign o8_Addr       = addr;
  assign o32_WrData    = {16'd0, wrData};
  assign o_Up          = up;
  assign o_Fail        = fail;
  assign o4_State      = state;
  assign o2_Retries    = retries;
  assign o8_LinkDrops  = drops;
  assign o16_LpAbility = lpAbility;

endmodule

// File: tb/tb_sgmii_link_manager.sv
// tb/tb_sgmii_link_manager.sv - directed bench for sgmii_link_manager
// Small Wishbone slave answers one cycle after Stb and logs every acknowledged transfer.
module tb_sgmii_link_manager;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        enable = 1'b0;
  logic        cyc, stb, wen;
  logic [7:0]  addr;
  logic [31:0] wrData;
  logic [31:0] rdData = 32'h0000_D801;
  logic        ack = 1'b0;
  logic        linkup = 1'b0;
  logic        anDone = 1'b0;
  logic        up, fail;
  logic [3:0]  state;
  logic [1:0]  retries;
  logic [7:0]  drops;
  logic [15:0] lpAbility;

  int nVec = 0;
  int nMiss = 0;
  int cycleNo = 0;
  logic ackEn = 1'b1;
  logic seenPrev = 1'b0;
  logic        logW[$];
  logic [7:0]  logA[$];
  logic [31:0] logD[$];
  int          logT[$];

  sgmii_link_manager #(
    .P_LINK_TO(24'd100),
    .P_AN_TO(24'd50),
    .P_BUS_TO(8'd8)
  ) dut (
    .i_Clk(clk), .i_ARst_L(rstN), .i_Enable(enable),
    .o_Cyc(cyc), .o_Stb(stb), .o_WEn(wen), .o8_Addr(addr), .o32_WrData(wrData),
    .i32_RdData(rdData), .i_Ack(ack), .i_Linkup(linkup), .i_ANDone(anDone),
    .o_Up(up), .o_Fail(fail), .o4_State(state), .o2_Retries(retries),
    .o8_LinkDrops(drops), .o16_LpAbility(lpAbility)
  );

  initial forever #4 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    cycleNo++;
    ack = ackEn && cyc && stb && seenPrev;
    seenPrev = cyc && stb;
    if (ack) begin
      logW.push_back(wen); logA.push_back(addr); logD.push_back(wrData); logT.push_back(cycleNo);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic chkTx(input string tag, input int idx, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic chkData);
    logic [40:0] got, exp;
    got = (idx < logA.size()) ? {logW[idx], logA[idx], chkData ? logD[idx] : 32'd0} : 41'h1_FFFF_FFFF_FF;
    exp = {w, a, chkData ? d : 32'd0};
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got {wen,addr,data}='h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic waitState(input string tag, input logic [3:0] s, input int budget);
    for (int i = 0; i < budget && state !== s; i++) @(negedge clk);
    chkVal(tag, {28'd0, state}, {28'd0, s});
  endtask

  task automatic clearLog();
    logW.delete(); logA.delete(); logD.delete(); logT.delete();
  endtask

  initial begin
    int cnt, rstCnt, okDrops, wAn;
    logic sawCyc;
    repeat (2) @(negedge clk);
    chkVal("rst state", {28'd0, state}, 32'd0);
    chkVal("rst cyc/stb/wen", {29'd0, cyc, stb, wen}, 32'd0);
    chkVal("rst addr", {24'd0, addr}, 32'd0);
    chkVal("rst wrdata", wrData, 32'd0);
    chkVal("rst up/fail", {30'd0, up, fail}, 32'd0);
    chkVal("rst retries/drops", {22'd0, retries, drops}, 32'd0);
    chkVal("rst lpa", {16'd0, lpAbility}, 32'd0);
    rstN = 1'b1;

    // nominal bring-up
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chkVal("enable->stb latency", {31'd0, stb}, 32'd1);
    chkVal("first state", {28'd0, state}, 32'd1);
    waitState("reach WAIT_LINK", 4'd4, 50);
    repeat (20) @(negedge clk);
    linkup = 1'b1;
    repeat (30) @(negedge clk);
    anDone = 1'b1;
    waitState("nominal UP", 4'd7, 50);
    anDone = 1'b0;
    chkVal("nominal tx count", logA.size(), 32'd4);
    chkTx("tx0 adv", 0, 1'b1, 8'h04, 32'h4001, 1'b1);
    chkTx("tx1 restart", 1, 1'b1, 8'h00, 32'h1200, 1'b1);
    chkTx("tx2 run", 2, 1'b1, 8'h00, 32'h1000, 1'b1);
    chkTx("tx3 read lpa", 3, 1'b0, 8'h05, 32'h0, 1'b0);
    chkVal("write spacing", (logT.size() > 1) ? logT[1] - logT[0] : -1, 32'd3);
    chkVal("lpa captured", {16'd0, lpAbility}, 32'h0000_D801);
    chkVal("nominal up", {31'd0, up}, 32'd1);
    chkVal("nominal retries", {30'd0, retries}, 32'd0);

    // link drop and recovery
    clearLog();
    linkup = 1'b0;
    @(negedge clk);
    chkVal("drop up low", {31'd0, up}, 32'd0);
    chkVal("drop count 1", {24'd0, drops}, 32'd1);
    chkVal("drop state WR_RST", {28'd0, state}, 32'd2);
    repeat (4) @(negedge clk);
    linkup = 1'b1;
    anDone = 1'b1;
    waitState("drop recover UP", 4'd7, 100);
    chkTx("drop tx0 restart", 0, 1'b1, 8'h00, 32'h1200, 1'b1);
    chkTx("drop tx1 run", 1, 1'b1, 8'h00, 32'h1000, 1'b1);
    chkVal("drop up again", {31'd0, up}, 32'd1);
    okDrops = 0;
    for (int i = 1; i < 300; i++) begin
      linkup = 1'b0;
      @(negedge clk);
      linkup = 1'b1;
      cnt = 0;
      while (state !== 4'd7 && cnt < 100) begin @(negedge clk); cnt++; end
      if (cnt < 100) okDrops++;
    end
    chkVal("299 drops recovered", okDrops, 32'd299);
    chkVal("drops saturate", {24'd0, drops}, 32'd255);

    // AN timeout retries to FAIL
    enable = 1'b0;
    anDone = 1'b0;
    @(negedge clk);
    chkVal("disable to IDLE", {28'd0, state}, 32'd0);
    chkVal("disable up low", {31'd0, up}, 32'd0);
    clearLog();
    enable = 1'b1;
    wAn = 0;
    for (int i = 0; i < 1000 && state !== 4'd8; i++) begin
      @(negedge clk);
      if (state == 4'd5 && retries == 2'd0) wAn++;
    end
    chkVal("AN timeout residency", wAn, 32'd51);
    chkVal("antimeout state FAIL", {28'd0, state}, 32'd8);
    chkVal("antimeout fail", {31'd0, fail}, 32'd1);
    chkVal("antimeout retries", {30'd0, retries}, 32'd3);
    chkVal("antimeout tx count", logA.size(), 32'd9);
    cnt = 0;
    foreach (logA[i]) if (logA[i] == 8'h00 && logD[i] == 32'h1200) cnt++;
    chkVal("antimeout restarts", cnt, 32'd4);
    enable = 1'b0;
    @(negedge clk);
    chkVal("fail exit IDLE", {28'd0, state}, 32'd0);
    chkVal("fail cleared", {31'd0, fail}, 32'd0);

    // bus timeout
    linkup = 1'b0;
    ackEn = 1'b0;
    enable = 1'b1;
    cnt = 0;
    sawCyc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cyc) begin cnt++; sawCyc = 1'b1; end
      else if (sawCyc) break;
    end
    chkVal("bus timeout cyc cycles", cnt, 32'd9);
    chkVal("bus timeout state", {28'd0, state}, 32'd8);
    chkVal("bus timeout cyc low", {31'd0, cyc}, 32'd0);
    enable = 1'b0;
    @(negedge clk);

    // disable while waiting for ack
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chkVal("disable held cyc", {31'd0, cyc}, 32'd1);
    chkVal("disable held state", {28'd0, state}, 32'd1);
    ackEn = 1'b1;
    for (int i = 0; i < 10 && cyc; i++) @(negedge clk);
    chkVal("disable done state", {28'd0, state}, 32'd0);
    chkVal("disable done cyc", {31'd0, cyc}, 32'd0);

    // reset mid-transaction
    enable = 1'b1;
    for (int i = 0; i < 50 && !(state == 4'd2 && stb); i++) @(negedge clk);
    chkVal("reached WR_RST stb", {27'd0, state, stb}, {27'd0, 4'd2, 1'b1});
    rstN = 1'b0;
    #1;
    chkVal("async rst state", {28'd0, state}, 32'd0);
    chkVal("async rst bus", {29'd0, cyc, stb, wen}, 32'd0);
    chkVal("async rst addr/data", {addr, wrData[23:0]}, 32'd0);
    chkVal("async rst drops", {24'd0, drops}, 32'd0);
    chkVal("async rst lpa", {16'd0, lpAbility}, 32'd0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    rstN = 1'b1;
    rstCnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (cyc || state != 4'd0) rstCnt++;
    end
    chkVal("post-reset quiet", rstCnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
